pc_sequencer: RTL and testbench

Parametrised program-counter unit for the fetch stage. It holds the PC register and predicts next fetch addresses through a direct-mapped branch target buffer (BTB). It resolves B/BEQZ/BNEZ/BTEQZ/JR outcomes arriving from decode, and sequences interrupt entry and return through a saved EPC. It replaces the purely combinational next-PC adder with a registered, predicting, interrupt-aware sequencer.

---
 rtl/pc_sequencer_pkg.sv | 34 +++
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer_btb.sv | 56 +++++
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_pkg: shared types for the fetch-stage PC sequencer.
//   - br_ctrl encodings for resolving control-flow instructions
//   - sequencer state enum (RUN / HANDLER)
//   - BTB entry struct (valid, tag, target)
// The BTB entry fields are sized to BTB_FIELD_W so one struct serves every
// PC_WIDTH up to that limit. Narrower configurations zero-extend into it.
package pc_pkg;

  localparam logic [2:0] BR_NONE  = 3'd0;
  localparam logic [2:0] BR_B     = 3'd1;
  localparam logic [2:0] BR_BEQZ  = 3'd2;
  localparam logic [2:0] BR_BNEZ  = 3'd3;
  localparam logic [2:0] BR_BTEQZ = 3'd4;
  localparam logic [2:0] BR_JR    = 3'd5;

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } pc_state_e;

  localparam int BTB_FIELD_W = 32;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
  } btb_entry_t;

  // Codes 6 and 7 behave like NONE: no outcome and no BTB activity.
  function automatic logic is_ctrl_flow(input logic [2:0] ctrl);
    return (ctrl >= BR_B) && (ctrl <= BR_JR);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch/resolve bus between decode and the PC sequencer.
//   Resolve side (decode -> sequencer): br_valid, br_ctrl, br_pc, br_imm,
//     br_reg, br_t, br_pred_taken, br_pred_target.
//   Fetch side (sequencer -> decode/fetch): fetch_pc, pred_taken,
//     pred_target, flush.
// master = decode/fetch pipeline, slave = pc_sequencer.
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 16
);
  logic [PC_WIDTH-1:0] fetch_pc;
  logic                pred_taken;
  logic [PC_WIDTH-1:0] pred_target;
  logic                flush;

  logic                br_valid;
  logic [2:0]          br_ctrl;
  logic [PC_WIDTH-1:0] br_pc;
  logic [PC_WIDTH-1:0] br_imm;
  logic [PC_WIDTH-1:0] br_reg;
  logic                br_t;
  logic                br_pred_taken;
  logic [PC_WIDTH-1:0] br_pred_target;

  modport master (
    output br_valid, br_ctrl, br_pc, br_imm, br_reg, br_t,
           br_pred_taken, br_pred_target,
    input  fetch_pc, pred_taken, pred_target, flush
  );

  modport slave (
    input  br_valid, br_ctrl, br_pc, br_imm, br_reg, br_t,
           br_pred_taken, br_pred_target,
    output fetch_pc, pred_taken, pred_target, flush
  );
endinterface

// File: rtl/pc_sequencer_btb.sv
// branch_target_buffer: direct-mapped BTB.
//   clock, reset     : rising-edge clock, async active-low clear of all entries
//   rd_pc            : combinational lookup address
//   rd_hit/rd_target : hit flag and target (target is 0 on a miss)
//   wr_en            : a control-flow instruction resolves this cycle
//   wr_set           : 1 = taken (install entry), 0 = not taken (invalidate
//                      the entry only if it is valid and its tag matches)
//   wr_pc/wr_target  : resolving instruction address and its taken target
// Reads see the pre-edge contents, so a same-index write is not forwarded.
module branch_target_buffer
  import pc_pkg::*;
#(
  parameter int PC_WIDTH  = 16,
  parameter int BTB_DEPTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] rd_pc,
  output logic                rd_hit,
  output logic [PC_WIDTH-1:0] rd_target,
  input  logic                wr_en,
  input  logic                wr_set,
  input  logic [PC_WIDTH-1:0] wr_pc,
  input  logic [PC_WIDTH-1:0] wr_target
);
  localparam int IDX_W = $clog2(BTB_DEPTH);

  btb_entry_t mem_q [BTB_DEPTH];

  logic [IDX_W-1:0]       rd_idx, wr_idx;
  logic [BTB_FIELD_W-1:0] rd_tag, wr_tag;

  // Tag is everything above the index, zero-extended into the entry field.
  assign rd_idx = rd_pc[IDX_W-1:0];
  assign wr_idx = wr_pc[IDX_W-1:0];
  assign rd_tag = BTB_FIELD_W'(rd_pc >> IDX_W);
  assign wr_tag = BTB_FIELD_W'(wr_pc >> IDX_W);

  assign rd_hit    = mem_q[rd_idx].valid && (mem_q[rd_idx].tag == rd_tag);
  assign rd_target = rd_hit ? mem_q[rd_idx].target[PC_WIDTH-1:0] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BTB_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      if (wr_set) begin
        mem_q[wr_idx] <= '{valid:  1'b1,
                           tag:    wr_tag,
                           target: BTB_FIELD_W'(wr_target)};
      end else if (mem_q[wr_idx].valid && (mem_q[wr_idx].tag == wr_tag)) begin
        mem_q[wr_idx].valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered, BTB-predicting, interrupt-aware program counter.
//   clock, reset : rising-edge clock, async active-low reset
//   stall        : hold fetch_pc (any redirect overrides)
//   bus          : slave side of pc_sequencer_if (fetch outputs, resolve inputs)
//   int_req      : level interrupt request, taken only in RUN
//   eret         : return-from-interrupt pulse, honoured only in HANDLER
//   int_ack      : interrupt entry this cycle
//   epc          : saved return address
//   in_handler   : sequencer is in HANDLER
// Next-PC priority: interrupt entry, eret, mispredict, stall, BTB hit, +1.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 16'h8000,
  parameter logic [PC_WIDTH-1:0] INT_VECTOR   = 16'h0008,
  parameter int                  BTB_DEPTH    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  pc_sequencer_if.slave       bus,
  input  logic                int_req,
  input  logic                eret,
  output logic                int_ack,
  output logic [PC_WIDTH-1:0] epc,
  output logic                in_handler
);
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] epc_q, epc_d;
  pc_state_e           state_q, state_d;

  logic                act_taken;
  logic [PC_WIDTH-1:0] act_target, fall_pc, correct_pc;
  logic                mispred;
  logic                btb_wr_en;
  logic                btb_hit;
  logic [PC_WIDTH-1:0] btb_target;
  logic                int_entry, eret_acc;

  // ---------------- branch outcome ----------------
  always_comb begin
    act_taken = 1'b0;
    case (bus.br_ctrl)
      BR_B, BR_JR: act_taken = 1'b1;
      BR_BEQZ:     act_taken = (bus.br_reg == '0);
      BR_BNEZ:     act_taken = (bus.br_reg != '0);
      BR_BTEQZ:    act_taken = !bus.br_t;
      default:     act_taken = 1'b0;
    endcase
  end

  // Sums stay PC_WIDTH wide so they wrap silently at all-ones.
  assign fall_pc    = bus.br_pc + PC_WIDTH'(1);
  assign act_target = (bus.br_ctrl == BR_JR) ? bus.br_reg : fall_pc + bus.br_imm;
  assign correct_pc = act_taken ? act_target : fall_pc;

  // Target only matters when both sides agree the branch is taken.
  assign mispred = bus.br_valid &&
                   ((act_taken != bus.br_pred_taken) ||
                    (act_taken && bus.br_pred_taken &&
                     (act_target != bus.br_pred_target)));

  assign btb_wr_en = bus.br_valid && is_ctrl_flow(bus.br_ctrl);

  branch_target_buffer #(
    .PC_WIDTH  (PC_WIDTH),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clock     (clock),
    .reset     (reset),
    .rd_pc     (fetch_pc_q),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (btb_wr_en),
    .wr_set    (act_taken),
    .wr_pc     (bus.br_pc),
    .wr_target (act_target)
  );

  // ---------------- state machine ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (int_req) state_d = HANDLER;
      HANDLER: if (eret)    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Combinational outputs are held low while reset is asserted so that
  // stray inputs during reset cannot produce a flush or acknowledge.
  always_comb begin
    int_entry      = (state_q == RUN) && int_req;
    eret_acc       = (state_q == HANDLER) && eret;
    int_ack        = reset && int_entry;
    in_handler     = reset && (state_q == HANDLER);
    bus.flush      = reset && (mispred || int_entry || eret_acc);
    bus.pred_taken = reset && btb_hit;
    bus.pred_target = (reset && btb_hit) ? btb_target : '0;
  end

  // ---------------- next PC / EPC ----------------
  always_comb begin
    if (int_entry)     fetch_pc_d = INT_VECTOR;
    else if (eret_acc) fetch_pc_d = epc_q;
    else if (mispred)  fetch_pc_d = correct_pc;
    else if (stall)    fetch_pc_d = fetch_pc_q;
    else if (btb_hit)  fetch_pc_d = btb_target;
    else               fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
  end

  // A mispredict resolving alongside interrupt entry means fetch_pc is on
  // the wrong path; the return address must be the corrected one.
  always_comb begin
    epc_d = epc_q;
    if (int_entry) epc_d = mispred ? correct_pc : fetch_pc_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_VECTOR;
      epc_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      epc_q      <= epc_d;
    end
  end

  assign bus.fetch_pc = fetch_pc_q;
  assign epc          = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_pkg::*;

  logic        clock, reset, stall, int_req, eret;
  logic        int_ack, in_handler;
  logic [15:0] epc;

  pc_sequencer_if #(.PC_WIDTH(16)) bus ();

  pc_sequencer #(
    .PC_WIDTH     (16),
    .RESET_VECTOR (16'h8000),
    .INT_VECTOR   (16'h0008),
    .BTB_DEPTH    (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .bus        (bus),
    .int_req    (int_req),
    .eret       (eret),
    .int_ack    (int_ack),
    .epc        (epc),
    .in_handler (in_handler)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected fetch_pc after the next rising edge.
  task automatic expect_pc(input string tag, input logic [15:0] pc);
    exp_t e;
    e.tag = tag;
    e.pc  = pc;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, {16'h0, bus.fetch_pc}, {16'h0, e.pc});
    end
  endtask

  task automatic br_idle();
    bus.br_valid       = 1'b0;
    bus.br_ctrl        = BR_NONE;
    bus.br_pc          = '0;
    bus.br_imm         = '0;
    bus.br_reg         = '0;
    bus.br_t           = 1'b0;
    bus.br_pred_taken  = 1'b0;
    bus.br_pred_target = '0;
  endtask

  task automatic br_drive(input logic [2:0] ctrl, input logic [15:0] pc,
                          input logic [15:0] imm, input logic [15:0] rg,
                          input logic pt, input logic [15:0] ptgt);
    bus.br_valid       = 1'b1;
    bus.br_ctrl        = ctrl;
    bus.br_pc          = pc;
    bus.br_imm         = imm;
    bus.br_reg         = rg;
    bus.br_t           = 1'b0;
    bus.br_pred_taken  = pt;
    bus.br_pred_target = ptgt;
  endtask

  // Redirect fetch to an arbitrary address via a mispredicted JR at 9003.
  task automatic jump(input logic [15:0] tgt);
    br_drive(BR_JR, 16'h9003, 16'h0, tgt, 1'b0, 16'h0);
    #1;
    chk("jump_flush", {31'h0, bus.flush}, 32'h1);
    expect_pc("jump_pc", tgt);
    tick();
    br_idle();
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; int_req = 1'b0; eret = 1'b0;
    br_idle();
    #12;
    chk("rst_fetch",   {16'h0, bus.fetch_pc},    32'h8000);
    chk("rst_flush",   {31'h0, bus.flush},       32'h0);
    chk("rst_ack",     {31'h0, int_ack},         32'h0);
    chk("rst_ptaken",  {31'h0, bus.pred_taken},  32'h0);
    chk("rst_ptgt",    {16'h0, bus.pred_target}, 32'h0);
    chk("rst_inh",     {31'h0, in_handler},      32'h0);
    chk("rst_epc",     {16'h0, epc},             32'h0);
    reset = 1'b1;

    // sequential fetch, then stall
    expect_pc("seq1", 16'h8001); tick();
    expect_pc("seq2", 16'h8002); tick();
    chk("seq_flush", {31'h0, bus.flush}, 32'h0);
    stall = 1'b1;
    expect_pc("stall1", 16'h8002); tick();
    expect_pc("stall2", 16'h8002); tick();
    stall = 1'b0;

    // B at 8010 +5 predicted not taken
    br_drive(BR_B, 16'h8010, 16'h0005, 16'h0, 1'b0, 16'h0);
    #1;
    chk("b_flush", {31'h0, bus.flush}, 32'h1);
    expect_pc("b_redirect", 16'h8016); tick();
    br_idle();

    jump(16'h8010);
    chk("btb_hit",  {31'h0, bus.pred_taken},  32'h1);
    chk("btb_tgt",  {16'h0, bus.pred_target}, 32'h8016);
    expect_pc("btb_follow", 16'h8016); tick();

    // BEQZ at 8010, reg=3, predicted taken to 8016 -> not taken
    br_drive(BR_BEQZ, 16'h8010, 16'h0005, 16'h0003, 1'b1, 16'h8016);
    #1;
    chk("beqz_flush", {31'h0, bus.flush}, 32'h1);
    expect_pc("beqz_fall", 16'h8011); tick();
    br_idle();
    jump(16'h8010);
    chk("btb_inval", {31'h0, bus.pred_taken},  32'h0);
    chk("btb_inv_t", {16'h0, bus.pred_target}, 32'h0);
    expect_pc("inval_seq", 16'h8011); tick();

    // correctly predicted JR: no flush
    br_drive(BR_JR, 16'h9003, 16'h0, 16'h8010, 1'b1, 16'h8010);
    #1;
    chk("jr_ok_flush", {31'h0, bus.flush}, 32'h0);
    expect_pc("jr_ok_seq", 16'h8012); tick();
    br_idle();

    // interrupt entry / ignore nested / eret
    jump(16'h8020);
    int_req = 1'b1;
    #1;
    chk("int_ack",   {31'h0, int_ack},   32'h1);
    chk("int_flush", {31'h0, bus.flush}, 32'h1);
    expect_pc("int_vec", 16'h0008); tick();
    chk("int_epc", {16'h0, epc},        32'h8020);
    chk("int_inh", {31'h0, in_handler}, 32'h1);
    chk("nest_ack",   {31'h0, int_ack},   32'h0);
    chk("nest_flush", {31'h0, bus.flush}, 32'h0);
    expect_pc("nest_seq", 16'h0009); tick();
    int_req = 1'b0;
    eret = 1'b1;
    #1;
    chk("eret_flush", {31'h0, bus.flush}, 32'h1);
    expect_pc("eret_pc", 16'h8020); tick();
    chk("eret_inh", {31'h0, in_handler}, 32'h0);
    // eret again, now in RUN: ignored
    #1;
    chk("eret_run_flush", {31'h0, bus.flush}, 32'h0);
    expect_pc("eret_run_seq", 16'h8021); tick();
    eret = 1'b0;

    // JR mispredict coinciding with interrupt entry
    br_drive(BR_JR, 16'h9005, 16'h0, 16'h1234, 1'b0, 16'h0);
    int_req = 1'b1;
    #1;
    chk("mix_ack",   {31'h0, int_ack},   32'h1);
    chk("mix_flush", {31'h0, bus.flush}, 32'h1);
    expect_pc("mix_vec", 16'h0008); tick();
    br_idle();
    int_req = 1'b0;
    chk("mix_epc", {16'h0, epc}, 32'h1234);
    eret = 1'b1;
    expect_pc("mix_eret", 16'h1234); tick();
    eret = 1'b0;

    // wrap-around
    jump(16'hFFFF);
    chk("wrap_nohit", {31'h0, bus.pred_taken}, 32'h0);
    expect_pc("wrap_inc", 16'h0000); tick();
    br_drive(BR_B, 16'hFFFF, 16'h0000, 16'h0, 1'b0, 16'h0);
    #1;
    chk("wrap_b_flush", {31'h0, bus.flush}, 32'h1);
    expect_pc("wrap_b_tgt", 16'h0000); tick();
    br_idle();
    jump(16'hFFFF);
    chk("wrap_hit", {31'h0, bus.pred_taken},  32'h1);
    chk("wrap_tgt", {16'h0, bus.pred_target}, 32'h0);

    // enter handler, then reset mid-operation
    int_req = 1'b1;
    expect_pc("pre_rst_vec", 16'h0008); tick();
    #2;
    reset = 1'b0;
    br_drive(BR_B, 16'h8000, 16'h0040, 16'h0, 1'b0, 16'h0);
    #1;
    chk("mrst_fetch", {16'h0, bus.fetch_pc}, 32'h8000);
    chk("mrst_epc",   {16'h0, epc},          32'h0);
    chk("mrst_inh",   {31'h0, in_handler},   32'h0);
    chk("mrst_flush", {31'h0, bus.flush},    32'h0);
    chk("mrst_ack",   {31'h0, int_ack},      32'h0);
    br_idle();
    int_req = 1'b0;
    reset = 1'b1;
    expect_pc("post_rst_seq", 16'h8001); tick();
    jump(16'hFFFF);
    chk("post_rst_btb", {31'h0, bus.pred_taken}, 32'h0);

    chk("sb_drain", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
